intersection_phase_scheduler: RTL

// Sequences a shared intersection between one highway and three requesters:

---
 rtl/intersection_phase_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// Intersection phase scheduler: highway holds green by default; after a
// minimum green, one pending side requester (local road, farm road or
// pedestrian) is granted a phase in round-robin order.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | HW_G   highway green, cnt saturates at min green, waits for request
//   1   | HW_Y   highway yellow
//   2   | RED1   all-red before side phase
//   3   | SIDE_G granted road green, or pedestrian walk
//   4   | SIDE_Y granted road yellow, or pedestrian clearance
//   5   | RED2   all-red before returning to highway green
module intersection_phase_scheduler #(
  parameter int HW_MIN_GREEN = 70,
  parameter int SIDE_GREEN   = 25,
  parameter int PED_WALK     = 15,
  parameter int YELLOW       = 5,
  parameter int ALL_RED      = 1,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lr_has_car_i,
  input  logic       fr_has_car_i,
  input  logic       ped_req_i,
  output logic [2:0] hw_light_o,
  output logic [2:0] lr_light_o,
  output logic [2:0] fr_light_o,
  output logic       ped_walk_o,
  output logic [2:0] state_o,
  output logic [1:0] grant_o
);

  typedef enum logic [2:0] {
    S_HW_G   = 3'd0,
    S_HW_Y   = 3'd1,
    S_RED1   = 3'd2,
    S_SIDE_G = 3'd3,
    S_SIDE_Y = 3'd4,
    S_RED2   = 3'd5
  } state_e;

  localparam logic [2:0] L_G = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b001;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_LR   = 2'd1;
  localparam logic [1:0] G_FR   = 2'd2;
  localparam logic [1:0] G_PED  = 2'd3;

  localparam logic [CNT_W-1:0] HW_LAST   = CNT_W'(HW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SG_LAST   = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(PED_WALK - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       rr_q, rr_d;
  logic             ped_pending_q, ped_pending_d;
  logic [2:0]       hw_q, hw_d;
  logic [2:0]       lr_q, lr_d;
  logic [2:0]       fr_q, fr_d;
  logic             walk_q, walk_d;

  // First active requester at or after the pointer, order lr -> fr -> ped -> lr.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic lr,
                                         input logic fr, input logic ped);
    logic [1:0] g;
    g = G_NONE;
    case (ptr)
      G_FR: begin
        if (fr)       g = G_FR;
        else if (ped) g = G_PED;
        else if (lr)  g = G_LR;
      end
      G_PED: begin
        if (ped)      g = G_PED;
        else if (lr)  g = G_LR;
        else if (fr)  g = G_FR;
      end
      default: begin
        if (lr)       g = G_LR;
        else if (fr)  g = G_FR;
        else if (ped) g = G_PED;
      end
    endcase
    return g;
  endfunction

  // State, counter, arbitration and registered output heads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HW_G;
      cnt_q         <= '0;
      grant_q       <= G_NONE;
      rr_q          <= G_LR;
      ped_pending_q <= 1'b0;
      hw_q          <= L_G;
      lr_q          <= L_R;
      fr_q          <= L_R;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      rr_q          <= rr_d;
      ped_pending_q <= ped_pending_d;
      hw_q          <= hw_d;
      lr_q          <= lr_d;
      fr_q          <= fr_d;
      walk_q        <= walk_d;
    end
  end

  // Phase sequencing, grant latch at highway exit, phase timer and ped latch.
  always_comb begin
    logic [1:0] pick;
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    pick    = rr_pick(rr_q, lr_has_car_i, fr_has_car_i, ped_pending_q);
    case (state_q)
      S_HW_G: begin
        if (cnt_q == HW_LAST && pick != G_NONE) begin
          state_d = S_HW_Y;
          grant_d = pick;
          rr_d    = (pick == G_PED) ? G_LR : pick + 2'd1;
        end
      end
      S_HW_Y:   if (cnt_q == Y_LAST)  state_d = S_RED1;
      S_RED1:   if (cnt_q == AR_LAST) state_d = S_SIDE_G;
      S_SIDE_G: if (cnt_q == ((grant_q == G_PED) ? WALK_LAST : SG_LAST)) state_d = S_SIDE_Y;
      S_SIDE_Y: if (cnt_q == Y_LAST)  state_d = S_RED2;
      S_RED2:   if (cnt_q == AR_LAST) state_d = S_HW_G;
      default:  state_d = S_HW_G;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q == S_HW_G && cnt_q == HW_LAST)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    // A press coinciding with the walk-entry clear still queues a new request.
    ped_pending_d = ped_req_i |
                    (ped_pending_q &
                     !(state_q == S_RED1 && state_d == S_SIDE_G && grant_q == G_PED));
  end

  // Head values for the upcoming state, so outputs move on the same edge as state.
  always_comb begin
    hw_d   = L_R;
    lr_d   = L_R;
    fr_d   = L_R;
    walk_d = 1'b0;
    case (state_d)
      S_HW_G: hw_d = L_G;
      S_HW_Y: hw_d = L_Y;
      S_SIDE_G: begin
        case (grant_d)
          G_LR:    lr_d   = L_G;
          G_FR:    fr_d   = L_G;
          G_PED:   walk_d = 1'b1;
          default: ;
        endcase
      end
      S_SIDE_Y: begin
        case (grant_d)
          G_LR:    lr_d = L_Y;
          G_FR:    fr_d = L_Y;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign hw_light_o = hw_q;
  assign lr_light_o = lr_q;
  assign fr_light_o = fr_q;
  assign ped_walk_o = walk_q;
  assign state_o    = state_q;
  assign grant_o    = grant_q;

endmodule
